// File: rtl/mips_debug_pkg.sv
// Shared definitions for the MIPS debug/program-load path.
//   - STATE_W / fsm_state_t : encoding of the fetch program controller FSM,
//                              also exported on its debug 'state' port
//   - LENGTH_DEFAULT        : datapath width of the fetch stage
//   - HALT_WORD_DEFAULT     : instruction encoding that ends a load and execution
package mips_debug_pkg;

    localparam int STATE_W        = 3;
    localparam int LENGTH_DEFAULT = 32;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [STATE_W-1:0] {
        LOAD  = 3'd0,
        READY = 3'd1,
        RUN   = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } fsm_state_t;

endpackage

// File: rtl/fetch_program_controller_word_assembler.sv
// word_assembler: packs a byte stream MSB-first into LENGTH-bit words.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   clear       : drops any partially assembled word
//   rx_byte     : incoming byte ('byte' is a reserved word in SystemVerilog)
//   valid       : rx_byte is valid this cycle
//   word        : completed word, meaningful while word_valid is high
//   word_valid  : combinational one-cycle pulse in the cycle the last byte arrives,
//                 so the consumer can register the write for the following cycle
module word_assembler #(
    parameter int LENGTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [7:0]        rx_byte,
    input  logic              valid,
    output logic [LENGTH-1:0] word,
    output logic              word_valid
);

    localparam int BYTES = LENGTH / 8;
    localparam int CNT_W = $clog2(BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

    // Only the first BYTES-1 bytes need storage; the last one completes the
    // word combinationally.
    logic [LENGTH-9:0] shift_q;
    logic [CNT_W-1:0]  byte_cnt;

    assign word       = {shift_q, rx_byte};
    assign word_valid = valid && !clear && (byte_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_q  <= '0;
            byte_cnt <= '0;
        end else if (valid) begin
            shift_q  <= {shift_q[LENGTH-17:0], rx_byte};
            byte_cnt <= (byte_cnt == LAST_CNT) ? '0 : byte_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_program_controller.sv
// fetch_program_controller: loads a program from the UART byte stream into
// instruction memory, then releases the fetch stage for free-run or
// single-step execution until the decode stage reports HALT.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   rx_data, rx_valid     : received byte and its one-cycle strobe
//   cmd_run, cmd_step     : run / single-step command pulses (honoured in READY only)
//   halt_fetched          : HALT_WORD has reached decode
//   instruction_to_write  : assembled instruction for memory
//   address_to_write      : word address of that instruction
//   write_enable          : one-cycle memory write strobe
//   start                 : fetch stage released from hold
//   pc_enable             : PC advance enable
//   state                 : current FSM state for debug readback
//   load_error            : sticky, memory filled before HALT_WORD was seen
module fetch_program_controller
    import mips_debug_pkg::*;
#(
    parameter int                LENGTH    = LENGTH_DEFAULT,
    parameter int                MEM_DEPTH = 256,
    parameter logic [LENGTH-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               cmd_run,
    input  logic               cmd_step,
    input  logic               halt_fetched,
    output logic [LENGTH-1:0]  instruction_to_write,
    output logic [LENGTH-1:0]  address_to_write,
    output logic               write_enable,
    output logic               start,
    output logic               pc_enable,
    output logic [STATE_W-1:0] state,
    output logic               load_error
);

    localparam logic [LENGTH-1:0] LAST_ADDR = LENGTH'(MEM_DEPTH - 1);

    fsm_state_t        state_q, state_d;
    logic [LENGTH-1:0] ptr_q;
    logic              started_q, started_d;
    logic              start_d, pc_enable_d, mark_error;
    logic              load_active;
    logic [LENGTH-1:0] asm_word;
    logic              asm_valid;

    assign load_active = (state_q == LOAD);
    assign state       = state_q;

    // Bytes outside LOAD are dropped and any partial word is flushed, so a
    // stray byte after loading can never leak into a later word.
    word_assembler #(.LENGTH(LENGTH)) u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (!load_active),
        .rx_byte    (rx_data),
        .valid      (rx_valid && load_active),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    // Output registers are loaded from the next-state decode so that start and
    // pc_enable change in the same cycle as the state they belong to.
    always_comb begin
        state_d    = state_q;
        mark_error = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (asm_valid) begin
                    if (asm_word == HALT_WORD) begin
                        state_d = READY;
                    end else if (ptr_q == LAST_ADDR) begin
                        state_d    = READY;
                        mark_error = 1'b1;
                    end
                end
            end
            READY: begin
                if (cmd_run) begin
                    state_d = RUN;
                end else if (cmd_step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (halt_fetched) begin
                    state_d = DONE;
                end
            end
            STEP: begin
                state_d = halt_fetched ? DONE : READY;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        started_d   = started_q || (state_d == RUN) || (state_d == STEP);
        pc_enable_d = (state_d == RUN) || (state_d == STEP);
        unique case (state_d)
            LOAD:    start_d = 1'b0;
            READY:   start_d = started_d;
            default: start_d = 1'b1;
        endcase
    end

    // The write pointer saturates on the last slot; the overflow case is
    // reported through load_error rather than by wrapping over slot 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q              <= LOAD;
            ptr_q                <= '0;
            started_q            <= 1'b0;
            instruction_to_write <= '0;
            address_to_write     <= '0;
            write_enable         <= 1'b0;
            start                <= 1'b0;
            pc_enable            <= 1'b0;
            load_error           <= 1'b0;
        end else begin
            state_q      <= state_d;
            started_q    <= started_d;
            start        <= start_d;
            pc_enable    <= pc_enable_d;
            write_enable <= asm_valid;
            if (asm_valid) begin
                address_to_write     <= ptr_q;
                instruction_to_write <= asm_word;
                if (ptr_q != LAST_ADDR) begin
                    ptr_q <= ptr_q + LENGTH'(1);
                end
            end
            if (mark_error) begin
                load_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_program_controller.sv
// Directed self-checking bench for fetch_program_controller.
// Two instances share all stimulus: dut (MEM_DEPTH=256) for load/step/run
// behaviour and dut_small (MEM_DEPTH=4) for the memory-overflow case.
module tb_fetch_program_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cmd_run;
    logic        cmd_step;
    logic        halt_fetched;

    logic [31:0] instruction_to_write, address_to_write;
    logic        write_enable, start, pc_enable, load_error;
    logic [2:0]  state;

    logic [31:0] s_instruction_to_write, s_address_to_write;
    logic        s_write_enable, s_start, s_pc_enable, s_load_error;
    logic [2:0]  s_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_program_controller dut (
        .clk                  (clk),
        .reset                (reset),
        .rx_data              (rx_data),
        .rx_valid             (rx_valid),
        .cmd_run              (cmd_run),
        .cmd_step             (cmd_step),
        .halt_fetched         (halt_fetched),
        .instruction_to_write (instruction_to_write),
        .address_to_write     (address_to_write),
        .write_enable         (write_enable),
        .start                (start),
        .pc_enable            (pc_enable),
        .state                (state),
        .load_error           (load_error)
    );

    fetch_program_controller #(.MEM_DEPTH(4)) dut_small (
        .clk                  (clk),
        .reset                (reset),
        .rx_data              (rx_data),
        .rx_valid             (rx_valid),
        .cmd_run              (cmd_run),
        .cmd_step             (cmd_step),
        .halt_fetched         (halt_fetched),
        .instruction_to_write (s_instruction_to_write),
        .address_to_write     (s_address_to_write),
        .write_enable         (s_write_enable),
        .start                (s_start),
        .pc_enable            (s_pc_enable),
        .state                (s_state),
        .load_error           (s_load_error)
    );

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; returns at the falling edge, away from the active edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Present one byte for a single cycle; returns after it has been sampled.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        applyStimulus(w[31:24]);
        applyStimulus(w[23:16]);
        applyStimulus(w[15:8]);
        applyStimulus(w[7:0]);
    endtask

    initial begin
        logic [31:0] w;
        reset        = 1'b1;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        cmd_run      = 1'b0;
        cmd_step     = 1'b0;
        halt_fetched = 1'b0;

        // 1. Reset
        tick();
        tick();
        checkOutput("rst_state", {29'd0, state}, 32'd0);
        checkOutput("rst_we", {31'd0, write_enable}, 32'd0);
        checkOutput("rst_start", {31'd0, start}, 32'd0);
        checkOutput("rst_pc", {31'd0, pc_enable}, 32'd0);
        checkOutput("rst_err", {31'd0, load_error}, 32'd0);
        checkOutput("rst_addr", address_to_write, 32'd0);
        reset = 1'b0;

        // 2. Load a two-word program ending in HALT
        applyStimulus(8'h20);
        applyStimulus(8'h08);
        applyStimulus(8'h00);
        checkOutput("ld_we_partial", {31'd0, write_enable}, 32'd0);
        applyStimulus(8'h05);
        checkOutput("ld0_we", {31'd0, write_enable}, 32'd1);
        checkOutput("ld0_addr", address_to_write, 32'd0);
        checkOutput("ld0_instr", instruction_to_write, 32'h2008_0005);
        checkOutput("ld0_state", {29'd0, state}, 32'd0);
        tick();
        checkOutput("ld0_we_off", {31'd0, write_enable}, 32'd0);
        sendWord(32'hFFFF_FFFF);
        checkOutput("ld1_we", {31'd0, write_enable}, 32'd1);
        checkOutput("ld1_addr", address_to_write, 32'd1);
        checkOutput("ld1_instr", instruction_to_write, 32'hFFFF_FFFF);
        checkOutput("ld1_state", {29'd0, state}, 32'd1);
        tick();
        checkOutput("ld1_we_off", {31'd0, write_enable}, 32'd0);
        sendWord(32'h1111_1111);
        checkOutput("ready_rx_ignored", {31'd0, write_enable}, 32'd0);
        checkOutput("ready_state", {29'd0, state}, 32'd1);
        checkOutput("ready_start", {31'd0, start}, 32'd0);
        checkOutput("ready_pc", {31'd0, pc_enable}, 32'd0);

        // 3. Single step, then simultaneous run+step
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
        checkOutput("step_state", {29'd0, state}, 32'd3);
        checkOutput("step_pc", {31'd0, pc_enable}, 32'd1);
        checkOutput("step_start", {31'd0, start}, 32'd1);
        tick();
        checkOutput("step_back_state", {29'd0, state}, 32'd1);
        checkOutput("step_back_pc", {31'd0, pc_enable}, 32'd0);
        checkOutput("step_back_start", {31'd0, start}, 32'd1);
        tick();
        checkOutput("step_pc_stays_low", {31'd0, pc_enable}, 32'd0);
        cmd_run  = 1'b1;
        cmd_step = 1'b1;
        tick();
        cmd_run  = 1'b0;
        cmd_step = 1'b0;
        checkOutput("both_state_run", {29'd0, state}, 32'd2);

        // 4. Run for ten cycles, then halt
        for (int i = 0; i < 10; i++) begin
            checkOutput("run_state", {29'd0, state}, 32'd2);
            checkOutput("run_pc", {31'd0, pc_enable}, 32'd1);
            tick();
        end
        halt_fetched = 1'b1;
        tick();
        halt_fetched = 1'b0;
        checkOutput("halt_state", {29'd0, state}, 32'd4);
        checkOutput("halt_pc", {31'd0, pc_enable}, 32'd0);
        checkOutput("halt_start", {31'd0, start}, 32'd1);
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        sendWord(32'h0000_0001);
        checkOutput("done_state", {29'd0, state}, 32'd4);
        checkOutput("done_we", {31'd0, write_enable}, 32'd0);
        checkOutput("done_pc", {31'd0, pc_enable}, 32'd0);

        // 5. Overflow on the four-word instance
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 32'hA0B0_C000 + i;
            sendWord(w);
            checkOutput("ovf_we", {31'd0, s_write_enable}, 32'd1);
            checkOutput("ovf_addr", s_address_to_write, i);
            checkOutput("ovf_instr", s_instruction_to_write, w);
            checkOutput("ovf_state", {29'd0, s_state}, (i == 3) ? 32'd1 : 32'd0);
            checkOutput("ovf_err", {31'd0, s_load_error}, (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        sendWord(32'h1234_0005);
        checkOutput("ovf_5th_we", {31'd0, s_write_enable}, 32'd0);
        checkOutput("ovf_5th_state", {29'd0, s_state}, 32'd1);
        checkOutput("ovf_5th_err", {31'd0, s_load_error}, 32'd1);
        checkOutput("big_no_err", {31'd0, load_error}, 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("ovf_rst_err", {31'd0, s_load_error}, 32'd0);
        checkOutput("ovf_rst_state", {29'd0, s_state}, 32'd0);
        reset = 1'b0;

        // 6. Reset mid-load discards the partial word
        applyStimulus(8'hAB);
        applyStimulus(8'hCD);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sendWord(32'h1234_5678);
        checkOutput("midrst_we", {31'd0, write_enable}, 32'd1);
        checkOutput("midrst_addr", address_to_write, 32'd0);
        checkOutput("midrst_instr", instruction_to_write, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
